// File: rtl/register_dump.sv
// Snapshots PC/A/X/Y/S/P on i_trigger and streams HEADER + registers (+ XOR checksum with REGISTER_DUMP_CHECKSUM_EN) as bytes.
// Latency: first byte valid the cycle after the trigger edge; o_valid/o_data hold while i_ready is low, no timeout.
module register_dump #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_pc,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_x,
  input  logic [7:0]  i_y,
  input  logic [7:0]  i_s,
  input  logic [7:0]  i_p,
  input  logic        i_trigger,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_busy,
  output logic        o_overrun
);

`ifdef REGISTER_DUMP_CHECKSUM_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif
  localparam logic [3:0] LAST = 4'(N - 1);

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  a;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  s;
    logic [7:0]  p;
  } regs_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  regs_t      snap;
  logic       capture;
  logic [7:0] byte_sel;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      snap      <= '0;
      o_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (capture) begin
        snap <= {i_pc, i_a, i_x, i_y, i_s, i_p};
      end
      // A trigger during a frame is dropped, even on the final-transfer edge.
      if (i_trigger && state == SEND) begin
        o_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    case (state)
      IDLE: begin
        if (i_trigger) begin
          state_nxt = SEND;
          idx_nxt   = 4'd0;
          capture   = 1'b1;
        end
      end
      SEND: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        if (i_ready) begin
          if (idx == LAST) begin
            state_nxt = IDLE;
            idx_nxt   = 4'd0;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef REGISTER_DUMP_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = HEADER ^ snap.pc[15:8] ^ snap.pc[7:0] ^ snap.a ^ snap.x ^ snap.y ^ snap.s ^ snap.p;
`endif

  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      4'd0: byte_sel = HEADER;
      4'd1: byte_sel = snap.pc[15:8];
      4'd2: byte_sel = snap.pc[7:0];
      4'd3: byte_sel = snap.a;
      4'd4: byte_sel = snap.x;
      4'd5: byte_sel = snap.y;
      4'd6: byte_sel = snap.s;
      4'd7: byte_sel = snap.p;
`ifdef REGISTER_DUMP_CHECKSUM_EN
      4'd8: byte_sel = checksum;
`endif
      default: byte_sel = 8'h00;
    endcase
  end

  assign o_data = o_valid ? byte_sel : 8'h00;

endmodule

// File: tb/tb_register_dump.sv
// Bench for register_dump: directed scenarios plus randomized frames against a frame-list model.
module tb_register_dump;

`ifdef REGISTER_DUMP_CHECKSUM_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [7:0]  a, x, y, s, p;
  logic        trigger;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  register_dump #(.HEADER(8'hA5)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_pc      (pc),
    .i_a       (a),
    .i_x       (x),
    .i_y       (y),
    .i_s       (s),
    .i_p       (p),
    .i_trigger (trigger),
    .o_data    (data),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_busy    (busy),
    .o_overrun (overrun)
  );

  always #5 clk = ~clk;

  // Expected frame straight from the frame definition.
  function automatic void model(input logic [15:0] vpc, input logic [7:0] va, vx, vy, vs, vp);
    logic [7:0] ck;
    exp_q = {8'hA5, vpc[15:8], vpc[7:0], va, vx, vy, vs, vp};
    if (N == 9) begin
      ck = 8'h00;
      foreach (exp_q[i]) ck = ck ^ exp_q[i];
      exp_q.push_back(ck);
    end
  endfunction

  task automatic set_regs(input logic [15:0] vpc, input logic [7:0] va, vx, vy, vs, vp);
    pc = vpc; a = va; x = vx; y = vy; s = vs; p = vp;
    model(vpc, va, vx, vy, vs, vp);
  endtask

  task automatic scramble_regs();
    pc = 16'($urandom); a = 8'($urandom); x = 8'($urandom);
    y = 8'($urandom); s = 8'($urandom); p = 8'($urandom);
  endtask

  // Called at a negedge: record any transfer due at the coming edge, advance one cycle.
  task automatic tick();
    #1;
    if (valid === 1'b1 && ready === 1'b1) got.push_back(data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; trigger = 1'b0; ready = 1'b0;
    set_regs(16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    ready = 1'b1;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (valid !== 1'b0 || data !== 8'h00) begin
        bad++; $display("FAIL idle_ready valid=%b data=%h exp valid=0 data=00", valid, data);
      end
    end
    total++; if (got.size() != 0) begin bad++; $display("FAIL idle_emit got=%0d bytes exp=0", got.size()); end
  endtask

  task automatic test_basic();
    set_regs(16'h1234, 8'h56, 8'h78, 8'h9A, 8'hFD, 8'h24);
    got.delete();
    ready = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    total++; if (valid !== 1'b1 || data !== 8'hA5) begin
      bad++; $display("FAIL basic_latency valid=%b data=%h exp valid=1 data=a5", valid, data);
    end
    for (int i = 0; i < N; i++) begin
      total++; if (valid !== 1'b1 || busy !== 1'b1 || data !== exp_q[i]) begin
        bad++; $display("FAIL basic_byte%0d valid=%b busy=%b data=%h exp data=%h", i, valid, busy, data, exp_q[i]);
      end
      tick();
    end
    total++; if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("FAIL basic_end busy=%b valid=%b exp 0/0", busy, valid);
    end
    total++; if (got.size() != N) begin bad++; $display("FAIL basic_len got=%0d exp=%0d", got.size(), N); end
    if (N == 9) begin
      total++; if (exp_q[8] !== 8'hEE || (got.size() == 9 && got[8] !== 8'hEE)) begin
        bad++; $display("FAIL basic_checksum got=%h exp=ee", (got.size() == 9) ? got[8] : 8'hxx);
      end
    end
  endtask

  task automatic test_backpressure();
    set_regs(16'h1234, 8'h56, 8'h78, 8'h9A, 8'hFD, 8'h24);
    got.delete();
    ready = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    scramble_regs();
    for (int b = 0; b < N; b++) begin
      if (b == 0 || b == 3 || b == 7) begin
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          total++; if (valid !== 1'b1 || data !== exp_q[b]) begin
            bad++; $display("FAIL stall_b%0d_c%0d valid=%b data=%h exp data=%h", b, k, valid, data, exp_q[b]);
          end
        end
        ready = 1'b1;
      end
      tick();
    end
    total++; if (got.size() != N) begin bad++; $display("FAIL bp_len got=%0d exp=%0d", got.size(), N); end
    for (int i = 0; i < N && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_end busy=%b exp=0", busy); end
  endtask

  task automatic test_overrun();
    set_regs(16'hBEEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    got.delete();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pre got=%b exp=0", overrun); end
    ready = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int b = 0; b < N; b++) begin
      trigger = (b == 4 || b == N - 1);
      if (b == 4) set_regs(16'h5555, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA);
      tick();
      trigger = 1'b0;
      if (b == 4) begin
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
      end
    end
    model(16'hBEEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    total++; if (got.size() != N) begin bad++; $display("FAIL ovr_len got=%0d exp=%0d", got.size(), N); end
    for (int i = 0; i < N && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL ovr_byte%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    total++; if (busy !== 1'b0 || overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_end busy=%b overrun=%b exp 0/1", busy, overrun);
    end
    // Earliest legal re-trigger, one cycle after busy falls.
    set_regs(16'hC0DE, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    got.delete();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < N; i++) tick();
    total++; if (got.size() != N) begin bad++; $display("FAIL retrig_len got=%0d exp=%0d", got.size(), N); end
    for (int i = 0; i < N && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL retrig_byte%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_mid();
    set_regs(16'hFACE, 8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34);
    ready = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (data !== exp_q[5] || overrun !== 1'b1) begin
      bad++; $display("FAIL mid_pre data=%h overrun=%b exp data=%h overrun=1", data, overrun, exp_q[5]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (data !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL mid_reset data=%h valid=%b busy=%b overrun=%b exp 00/0/0/0", data, valid, busy, overrun);
    end
    got.delete();
    for (int i = 0; i < 4; i++) tick();
    total++; if (got.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_no_resume got=%0d busy=%b exp 0/0", got.size(), busy);
    end
    set_regs(16'h0F0F, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < N; i++) tick();
    total++; if (got.size() != N) begin bad++; $display("FAIL mid_len got=%0d exp=%0d", got.size(), N); end
    for (int i = 0; i < N && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL mid_byte%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int f = 0; f < 12; f++) begin
      set_regs(16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      got.delete();
      ready = ($urandom_range(0, 1) == 1);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      scramble_regs();
      cyc = 0;
      while (got.size() < N && cyc < 300) begin
        ready   = ($urandom_range(0, 2) != 0);
        trigger = busy && ($urandom_range(0, 4) == 0);
        tick();
        cyc++;
      end
      trigger = 1'b0;
      ready   = 1'b1;
      total++; if (got.size() != N || busy !== 1'b0) begin
        bad++; $display("FAIL rand%0d_len got=%0d busy=%b exp=%0d/0 cycles=%0d", f, got.size(), busy, N, cyc);
      end
      for (int i = 0; i < N && i < got.size(); i++) begin
        total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", f, i, got[i], exp_q[i]); end
      end
      for (int i = 0; i < $urandom_range(0, 2); i++) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
